boa_mem_arb: RTL and testbench
==============================

BOA_MEM_ARB -- requirements
Module: boa_mem_arb

Interface
- REQ-001 SHALL have parameter: prio_port, 0, port that wins simultaneous requests in fixed-priority mode and at reset in round-robin mode.
- REQ-002 SHALL have port: clk  input  1  CPU clock.
- REQ-003 SHALL have port: rst  input  1  reset; one clock, reset asynchronous and active-high.
- REQ-004 SHALL have port: m0  boa_mem_bus.MEM  bundle  requester 0 (instruction fetch).
- REQ-005 SHALL have port: m1  boa_mem_bus.MEM  bundle  requester 1 (load/store).
- REQ-006 SHALL have port: mem  boa_mem_bus.CPU  bundle  shared memory-side bus.
- REQ-007 Bundle fields SHALL be: re 1, we 4 (byte strobes), addr [31:2], wdata 32, rdata 32, ready 1.

Function
- REQ-008 Port N SHALL be requesting when mN.re=1 or mN.we!=0.
- REQ-009 SHALL implement state machine IDLE, OWN0, OWN1.
- REQ-010 An arbitration point SHALL be any cycle in IDLE, or any cycle in OWNx with mem.ready=1.
- REQ-011 At an arbitration point the winner's re/we/addr/wdata SHALL drive mem in the same cycle (zero added latency), and the state SHALL become OWNwinner at the next edge.
- REQ-012 At an arbitration point with no requester, mem.re=0 and mem.we=0, and the next state SHALL be IDLE.
- REQ-013 In OWNx with mem.ready=0, mem SHALL be driven from mx only; no re-arbitration; ownership SHALL be held even if mx drops its request.
- REQ-014 mx.ready SHALL equal mem.ready in state OWNx and SHALL be 0 otherwise; the non-owner's ready SHALL be 0.
- REQ-015 mem.rdata SHALL be broadcast to m0.rdata and m1.rdata unregistered.
- REQ-016 Back-to-back: when the owner's ready=1 and the owner presents a new request that wins, the new transaction SHALL issue in that same cycle with no idle cycle.
- REQ-017 Simultaneous requests at an arbitration point SHALL be resolved per REQ-022/REQ-023.
- REQ-018 A single requester SHALL always win regardless of mode.
- REQ-019 mem.we and mem.re SHALL never both come from different ports in one cycle; all mem request fields SHALL come from exactly one port or be idle.

Reset
- REQ-020 While rst=1: state=IDLE, mem.re=0, mem.we=0, m0.ready=0, m1.ready=0, round-robin pointer SHALL favour prio_port; requests SHALL be ignored.
- REQ-021 Reset asserted mid-transaction SHALL abandon the transaction immediately (asynchronous); the first arbitration point after deassertion SHALL be the first clock in IDLE.

Configuration
- REQ-022 With BOA_ARB_RR_EN defined: round-robin; a 1-bit last-served register SHALL update at each grant, and on simultaneous requests the port not last served SHALL win.
- REQ-023 Without BOA_ARB_RR_EN: fixed priority; prio_port SHALL always win simultaneous requests; no last-served register.

Structure
- REQ-024 Package boa_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1) and the port-index type.
- REQ-025 Sub-module boa_arb_pick SHALL be natural: combinational two-way winner selection (requests, pointer, mode) -> winner index and valid.
- REQ-026 State and pointer SHALL be the only flops; the datapath mux SHALL be combinational.

Verification
- REQ-027 Single requester: m0 re=1, addr=0x4000_0000, memory ready after 2 cycles -> mem.addr=0x4000_0000 same cycle; m0.ready=1 in cycle 2; m1.ready=0 throughout.
- REQ-028 Collision, fixed priority (prio_port=0): m0 and m1 request in the same cycle -> m0 is served first; m1 issues in m0's ready cycle with no idle gap.
- REQ-029 Collision, BOA_ARB_RR_EN: both ports request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- REQ-030 Hold: m1 writes we=4'b1111, wdata=0xDEADBEEF; m0 requests during wait -> mem fields stay m1's until ready; m0 is never granted early.
- REQ-031 Reset mid-transaction: rst pulses while in OWN1 -> mem.re=0, mem.we=0 and both readies=0 immediately; after release, a fresh m0 request is granted from IDLE.
- REQ-032 Owner drops request while waiting -> state stays OWNx until mem.ready=1, then IDLE.

Source files
------------

// File: rtl/boa_arb_pkg.sv
// boa_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_e : arbiter ownership state (IDLE, OWN0, OWN1)
//   port_idx_t  : requester index (0 = instruction fetch, 1 = load/store)
// Optional feature macro used by the arbiter: BOA_ARB_RR_EN (round-robin).
package boa_arb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned ADDR_LSB = 2;
    localparam int unsigned NUM_PORT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

    // Ownership state reached when port p wins.
    function automatic arb_state_e own_state(input port_idx_t p);
        return p ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// boa_mem_bus: word-addressed memory bus bundle.
//   re    : read request           we    : byte write strobes
//   addr  : word address [31:2]    wdata : write data
//   rdata : read data              ready : transaction complete
// Modport CPU drives a request; modport MEM answers it.
interface boa_mem_bus;
    import boa_arb_pkg::*;

    logic                       re;
    logic [STRB_W-1:0]          we;
    logic [31:ADDR_LSB]         addr;
    logic [DATA_W-1:0]          wdata;
    logic [DATA_W-1:0]          rdata;
    logic                       ready;

    modport CPU (output re, we, addr, wdata, input rdata, ready);
    modport MEM (input re, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/boa_arb_pick.sv
// boa_arb_pick: combinational two-way winner selection.
//   req_i   : request vector, bit N = port N requesting
//   last_i  : port served most recently (used in round-robin mode)
//   prio_i  : port that wins collisions in fixed-priority mode
//   rr_en_i : 1 = round-robin, 0 = fixed priority
//   win_o   : winning port index (valid only when vld_o=1)
//   vld_o   : at least one port is requesting
module boa_arb_pick
    import boa_arb_pkg::*;
(
    input  logic [NUM_PORT-1:0] req_i,
    input  port_idx_t           last_i,
    input  port_idx_t           prio_i,
    input  logic                rr_en_i,
    output port_idx_t           win_o,
    output logic                vld_o
);

    // A lone requester always wins; collisions go by mode.
    always_comb begin
        vld_o = |req_i;
        win_o = prio_i;
        unique case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = rr_en_i ? ~last_i : prio_i;
            default: win_o = prio_i;
        endcase
    end

endmodule

// File: rtl/boa_mem_arb.sv
// boa_mem_arb: arbitrates two requesters onto one shared memory bus.
//   clk  : CPU clock
//   rst  : asynchronous active-high reset
//   m0   : requester 0 (instruction fetch), MEM side of its bus
//   m1   : requester 1 (load/store), MEM side of its bus
//   mem  : shared memory bus, CPU side
// Parameter prio_port selects the collision winner in fixed-priority mode
// and the first winner after reset in round-robin mode.
// Define BOA_ARB_RR_EN for round-robin arbitration; default is fixed priority.
// The request path is combinational so a grant issues in the arbitration cycle.
module boa_mem_arb
    import boa_arb_pkg::*;
#(
    parameter port_idx_t prio_port = 1'b0
)
(
    input  logic         clk,
    input  logic         rst,
    boa_mem_bus.MEM      m0,
    boa_mem_bus.MEM      m1,
    boa_mem_bus.CPU      mem
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    port_idx_t           last_q;
    port_idx_t           win;
    port_idx_t           owner;
    port_idx_t           gnt_sel;
    logic                win_vld;
    logic                gnt_vld;
    logic                arb_pt;
    logic                req0;
    logic                req1;
    logic                rr_en;

    logic                mem_re;
    logic [STRB_W-1:0]   mem_we;
    logic [31:ADDR_LSB]  mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    // Request detection: read or any write strobe.
    assign req0   = m0.re | (|m0.we);
    assign req1   = m1.re | (|m1.we);

    // Re-arbitrate when idle or when the current transaction completes.
    assign arb_pt = (state_q == IDLE) | mem.ready;
    assign owner  = port_idx_t'(state_q == OWN1);

`ifdef BOA_ARB_RR_EN
    assign rr_en = 1'b1;

    // Last-served pointer; reset value makes prio_port win the first collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ~prio_port;
        end else if (arb_pt && win_vld) begin
            last_q <= win;
        end
    end
`else
    assign rr_en  = 1'b0;
    assign last_q = ~prio_port;
`endif

    boa_arb_pick u_pick (
        .req_i   ({req1, req0}),
        .last_i  (last_q),
        .prio_i  (prio_port),
        .rr_en_i (rr_en),
        .win_o   (win),
        .vld_o   (win_vld)
    );

    // Grant selection and next state; a waiting owner keeps the bus.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = owner;
        state_d = state_q;
        if (arb_pt) begin
            gnt_vld = win_vld;
            gnt_sel = win;
            state_d = win_vld ? own_state(win) : IDLE;
        end else begin
            gnt_vld = 1'b1;
        end
        // Requests are ignored while reset is held.
        if (rst) begin
            gnt_vld = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath mux: all request fields come from a single port or are idle.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_vld) begin
            if (gnt_sel) begin
                mem_re    = m1.re;
                mem_we    = m1.we;
                mem_addr  = m1.addr;
                mem_wdata = m1.wdata;
            end else begin
                mem_re    = m0.re;
                mem_we    = m0.we;
                mem_addr  = m0.addr;
                mem_wdata = m0.wdata;
            end
        end
    end

    assign mem.re    = mem_re;
    assign mem.we    = mem_we;
    assign mem.addr  = mem_addr;
    assign mem.wdata = mem_wdata;

    // Completion goes only to the owner; read data is broadcast.
    assign m0.ready  = (state_q == OWN0) & mem.ready;
    assign m1.ready  = (state_q == OWN1) & mem.ready;
    assign m0.rdata  = mem.rdata;
    assign m1.rdata  = mem.rdata;

endmodule

// File: tb/tb_boa_mem_arb.sv
// tb_boa_mem_arb: directed scenarios followed by random traffic, each cycle
// compared against a transaction-level ownership model of the arbiter.
module tb_boa_mem_arb;
    import boa_arb_pkg::*;

    localparam logic PRIO   = 1'b0;
    localparam int   PRIO_I = 0;
`ifdef BOA_ARB_RR_EN
    localparam bit   RR     = 1'b1;
`else
    localparam bit   RR     = 1'b0;
`endif

    localparam logic [29:0] A0 = 30'h0000_0100;
    localparam logic [29:0] A1 = 30'h0000_0200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boa_mem_bus m0_bus ();
    boa_mem_bus m1_bus ();
    boa_mem_bus mem_bus ();

    boa_mem_arb #(.prio_port(PRIO)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .mem (mem_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who holds the bus (-1 = nobody) and who was served last.
    int mdl_owner = -1;
    int mdl_last  = 1 - PRIO_I;
    int cur_win;
    bit cur_arb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic re, input logic [3:0] we,
                            input logic [29:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            m0_bus.re = re; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wd;
        end else begin
            m1_bus.re = re; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wd;
        end
    endtask

    // Settle, then compare every DUT output against the model.
    task automatic settle();
        bit r0, r1;
        logic        er;
        logic [3:0]  ew;
        logic [29:0] ea;
        logic [31:0] ed;
        #1;
        r0 = (m0_bus.re === 1'b1) || (m0_bus.we != 4'h0);
        r1 = (m1_bus.re === 1'b1) || (m1_bus.we != 4'h0);
        cur_win = -1;
        cur_arb = 1'b1;
        if (!rst) begin
            cur_arb = (mdl_owner < 0) || (mem_bus.ready === 1'b1);
            if (!cur_arb)        cur_win = mdl_owner;
            else if (r0 && r1)   cur_win = RR ? (1 - mdl_last) : PRIO_I;
            else if (r0)         cur_win = 0;
            else if (r1)         cur_win = 1;
        end
        er = 1'b0; ew = 4'h0; ea = '0; ed = '0;
        if (cur_win == 0) begin
            er = m0_bus.re; ew = m0_bus.we; ea = m0_bus.addr; ed = m0_bus.wdata;
        end else if (cur_win == 1) begin
            er = m1_bus.re; ew = m1_bus.we; ea = m1_bus.addr; ed = m1_bus.wdata;
        end
        check("mem_re", 64'(mem_bus.re), 64'(er));
        check("mem_we", 64'(mem_bus.we), 64'(ew));
        if (cur_win >= 0) begin
            check("mem_addr",  64'(mem_bus.addr),  64'(ea));
            check("mem_wdata", 64'(mem_bus.wdata), 64'(ed));
        end
        check("m0_ready", 64'(m0_bus.ready),
              64'(!rst && mdl_owner == 0 && mem_bus.ready === 1'b1));
        check("m1_ready", 64'(m1_bus.ready),
              64'(!rst && mdl_owner == 1 && mem_bus.ready === 1'b1));
        check("m0_rdata", 64'(m0_bus.rdata), 64'(mem_bus.rdata));
        check("m1_rdata", 64'(m1_bus.rdata), 64'(mem_bus.rdata));
    endtask

    // Clock edge: ownership follows the arbitration outcome.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = 1 - PRIO_I;
        end else if (cur_arb) begin
            mdl_owner = cur_win;
            if (cur_win >= 0) mdl_last = cur_win;
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        set_port(1, 1'b0, 4'h0, A1, 32'h0);
        mem_bus.ready = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        mem_bus.rdata = 32'h0;

        // Reset holds everything idle even with requests and ready present.
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        set_port(1, 1'b0, 4'hF, A1, 32'h1234_5678);
        mem_bus.ready = 1'b1;
        step();
        step();
        @(posedge clk); #1;
        rst = 1'b0;
        idle_all();
        step();

        // Single requester, ready after 2 cycles.
        set_port(0, 1'b1, 4'h0, 30'h1000_0000, 32'h0);
        settle();
        check("s1_addr", 64'(mem_bus.addr), 64'h1000_0000);
        check("s1_m1rdy_c0", 64'(m1_bus.ready), 64'h0);
        advance();
        step();
        mem_bus.ready = 1'b1;
        mem_bus.rdata = 32'hCAFE_0001;
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        settle();
        check("s1_m0rdy", 64'(m0_bus.ready), 64'h1);
        check("s1_m1rdy", 64'(m1_bus.ready), 64'h0);
        advance();
        mem_bus.ready = 1'b0;
        step();

        // Collision: prio port first, other issues in its ready cycle.
        pulse_reset();
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        set_port(1, 1'b1, 4'h0, A1, 32'h0);
        settle();
        check("s2_first", 64'(mem_bus.addr), 64'(A0));
        advance();
        step();
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        mem_bus.ready = 1'b1;
        settle();
        check("s2_m0rdy", 64'(m0_bus.ready), 64'h1);
        check("s2_b2b_re", 64'(mem_bus.re), 64'h1);
        check("s2_b2b_addr", 64'(mem_bus.addr), 64'(A1));
        advance();
        set_port(1, 1'b0, 4'h0, A1, 32'h0);
        settle();
        check("s2_m1rdy", 64'(m1_bus.ready), 64'h1);
        advance();
        mem_bus.ready = 1'b0;
        step();

        // Continuous collision for 6 single-cycle transactions.
        pulse_reset();
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        set_port(1, 1'b1, 4'h0, A1, 32'h0);
        mem_bus.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("s3_grant", 64'(mem_bus.addr == A1), RR ? 64'(i % 2) : 64'(PRIO_I));
            advance();
        end

        // Hold: waiting write owner keeps the bus against a new request.
        pulse_reset();
        set_port(1, 1'b0, 4'hF, A1, 32'hDEAD_BEEF);
        step();
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("s4_we", 64'(mem_bus.we), 64'hF);
            check("s4_wdata", 64'(mem_bus.wdata), 64'hDEAD_BEEF);
            check("s4_addr", 64'(mem_bus.addr), 64'(A1));
            advance();
        end
        set_port(1, 1'b0, 4'h0, A1, 32'h0);
        mem_bus.ready = 1'b1;
        settle();
        check("s4_m1rdy", 64'(m1_bus.ready), 64'h1);
        check("s4_m0gnt", 64'(mem_bus.addr), 64'(A0));
        advance();
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        step();
        mem_bus.ready = 1'b0;

        // Reset mid-transaction in OWN1.
        set_port(1, 1'b1, 4'h0, A1, 32'h0);
        step();
        mem_bus.ready = 1'b1;
        rst = 1'b1;
        settle();
        check("s5_re", 64'(mem_bus.re), 64'h0);
        check("s5_we", 64'(mem_bus.we), 64'h0);
        check("s5_m1rdy", 64'(m1_bus.ready), 64'h0);
        advance();
        rst = 1'b0;
        mem_bus.ready = 1'b0;
        set_port(1, 1'b0, 4'h0, A1, 32'h0);
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        settle();
        check("s5_fresh_re", 64'(mem_bus.re), 64'h1);
        check("s5_fresh_addr", 64'(mem_bus.addr), 64'(A0));
        advance();
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        mem_bus.ready = 1'b1;
        settle();
        check("s5_m0rdy", 64'(m0_bus.ready), 64'h1);
        advance();
        mem_bus.ready = 1'b0;

        // Owner drops its request while waiting.
        set_port(0, 1'b1, 4'h0, A0, 32'h0);
        step();
        set_port(0, 1'b0, 4'h0, A0, 32'h0);
        step();
        step();
        mem_bus.ready = 1'b1;
        settle();
        check("s6_m0rdy", 64'(m0_bus.ready), 64'h1);
        advance();
        settle();
        check("s6_idle_rdy", 64'(m0_bus.ready), 64'h0);
        advance();
        mem_bus.ready = 1'b0;

        // Random traffic with occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_port(0, 1'($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                     30'($urandom), $urandom);
            set_port(1, 1'($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                     30'($urandom), $urandom);
            mem_bus.ready = 1'($urandom_range(0, 1));
            mem_bus.rdata = $urandom;
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
